// File: rtl/kt_lowx_arbiter_pkg.sv
// Shared types for the lowX refill arbiter: FSM states, port index and
// request/response bundles sized for the default cache geometry.
package kt_cache_params;

  localparam int XLEN_DEF     = 32;
  localparam int BLK_SIZE_DEF = 128;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } arb_state_e;

  typedef logic arb_port_t;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_DEF-1:0]     addr;
  } arb_req_t;

  typedef struct packed {
    logic                    valid;
    logic [BLK_SIZE_DEF-1:0] data;
  } arb_res_t;

endpackage

// File: rtl/kt_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to rr_ptr.
module kt_rr_pick2
  import kt_cache_params::*;
(
  input  logic      valid0_i,
  input  logic      valid1_i,
  input  arb_port_t rr_ptr_i,
  output logic      gnt_valid_o,
  output arb_port_t gnt_idx_o
);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    gnt_idx_o   = 1'b0;
    if (valid0_i && valid1_i) begin
      gnt_idx_o = rr_ptr_i;
    end else if (valid1_i) begin
      gnt_idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/kt_lowx_arbiter.sv
// Shares the single lowX refill port between icache (port 0) and dcache
// (port 1): one transaction at a time, round-robin, with a sticky watchdog.
module kt_lowx_arbiter
  import kt_cache_params::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BLK_SIZE    = BLK_SIZE_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [XLEN-1:0]     req0_addr_i,
  output logic                res0_valid_o,
  input  logic                res0_ready_i,
  output logic [BLK_SIZE-1:0] res0_data_o,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [XLEN-1:0]     req1_addr_i,
  output logic                res1_valid_o,
  input  logic                res1_ready_i,
  output logic [BLK_SIZE-1:0] res1_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  input  logic                mem_res_valid_i,
  output logic                mem_res_ready_o,
  input  logic [BLK_SIZE-1:0] mem_res_data_i,
  output logic                grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  arb_port_t           r_grant;
  arb_port_t           r_rr_ptr;
  logic [XLEN-1:0]     r_addr;
  logic [BLK_SIZE-1:0] r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout;

  logic      w_gnt_valid;
  arb_port_t w_gnt_idx;
  logic      w_accept;
  logic      w_res_ready;
  logic      w_in_resp;
  logic      w_cnt_hit;

  kt_rr_pick2 u_pick (
    .valid0_i    (req0_valid_i),
    .valid1_i    (req1_valid_i),
    .rr_ptr_i    (r_rr_ptr),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx)
  );

  assign w_accept    = (r_state == S_IDLE) && w_gnt_valid;
  assign w_res_ready = r_grant ? res1_ready_i : res0_ready_i;
  assign w_in_resp   = (r_state == S_RESP);
  assign w_cnt_hit   = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid)     w_state_next = S_REQ;
      S_REQ:   if (mem_req_ready_i) w_state_next = S_WAIT;
      S_WAIT:  if (mem_res_valid_i) w_state_next = S_RESP;
      S_RESP:  if (w_res_ready)     w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_rr_ptr  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr   <= w_gnt_idx ? req1_addr_i : req0_addr_i;
        r_grant  <= w_gnt_idx;
        r_rr_ptr <= ~w_gnt_idx;
      end
      if (r_state == S_WAIT && mem_res_valid_i) begin
        r_data <= mem_res_data_i;
      end
      // Watchdog only reports; the transaction keeps waiting for its response.
      if (r_state == S_WAIT) begin
        if (r_cnt != CNT_W'(TIMEOUT_CYC)) r_cnt <= r_cnt + CNT_W'(1);
        if (w_cnt_hit && !mem_res_valid_i) r_timeout <= 1'b1;
      end else if (w_in_resp && w_res_ready) begin
        r_cnt <= '0;
      end
    end
  end

  assign req0_ready_o    = w_accept && (w_gnt_idx == 1'b0);
  assign req1_ready_o    = w_accept && (w_gnt_idx == 1'b1);
  assign mem_req_valid_o = (r_state == S_REQ);
  assign mem_req_addr_o  = r_addr;
  assign mem_res_ready_o = (r_state == S_WAIT);
  assign res0_valid_o    = w_in_resp && (r_grant == 1'b0);
  assign res1_valid_o    = w_in_resp && (r_grant == 1'b1);
  assign res0_data_o     = res0_valid_o ? r_data : '0;
  assign res1_data_o     = res1_valid_o ? r_data : '0;
  assign grant_o         = r_grant;
  assign busy_o          = (r_state != S_IDLE);
  assign timeout_o       = r_timeout;

endmodule

// File: tb/tb_kt_lowx_arbiter.sv
// Directed bench for kt_lowx_arbiter: single refill, fairness, stalls,
// watchdog, mid-transaction reset and a spurious lowX response.
module tb_kt_lowx_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req0_valid_i, req0_ready_o, res0_valid_o, res0_ready_i;
  logic         req1_valid_i, req1_ready_o, res1_valid_o, res1_ready_i;
  logic [31:0]  req0_addr_i, req1_addr_i, mem_req_addr_o;
  logic [127:0] res0_data_o, res1_data_o, mem_res_data_i;
  logic         mem_req_valid_o, mem_req_ready_i, mem_res_valid_i, mem_res_ready_o;
  logic         grant_o, busy_o, timeout_o;

  int n_chk = 0;
  int n_err = 0;

  kt_lowx_arbiter #(
    .XLEN        (32),
    .BLK_SIZE    (128),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req0_valid_i    (req0_valid_i),
    .req0_ready_o    (req0_ready_o),
    .req0_addr_i     (req0_addr_i),
    .res0_valid_o    (res0_valid_o),
    .res0_ready_i    (res0_ready_i),
    .res0_data_o     (res0_data_o),
    .req1_valid_i    (req1_valid_i),
    .req1_ready_o    (req1_ready_o),
    .req1_addr_i     (req1_addr_i),
    .res1_valid_o    (res1_valid_o),
    .res1_ready_i    (res1_ready_i),
    .res1_data_o     (res1_data_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_res_valid_i (mem_res_valid_i),
    .mem_res_ready_o (mem_res_ready_o),
    .mem_res_data_i  (mem_res_data_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #3;
    rst_i = 1'b0;
  endtask

  function automatic logic [127:0] blk_of(input logic [31:0] a);
    return {a, ~a, 32'hDA7A_0000, a ^ 32'h5A5A_5A5A};
  endfunction

  // Runs one full transaction for port p, starting in S_IDLE with valids already driven.
  task automatic serve(input string tag, input bit p, input logic [31:0] addr,
                       input logic [127:0] data, input int req_stall,
                       input int res_delay, input int resp_stall);
    #1;
    check({tag, ":rdy0"}, req0_ready_o, p == 1'b0);
    check({tag, ":rdy1"}, req1_ready_o, p == 1'b1);
    tick();
    check({tag, ":rdy_pulse"}, p ? req1_ready_o : req0_ready_o, 1'b0);
    check({tag, ":mreq_v"}, mem_req_valid_o, 1'b1);
    check({tag, ":mreq_a"}, mem_req_addr_o, addr);
    check({tag, ":grant"}, grant_o, p);
    for (int i = 0; i < req_stall; i++) begin
      tick();
      check({tag, ":stall_mreq_v"}, mem_req_valid_o, 1'b1);
      check({tag, ":stall_mreq_a"}, mem_req_addr_o, addr);
      check({tag, ":nogrant"}, req0_ready_o | req1_ready_o, 1'b0);
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check({tag, ":mreq_drop"}, mem_req_valid_o, 1'b0);
    check({tag, ":mres_rdy"}, mem_res_ready_o, 1'b1);
    for (int i = 0; i < res_delay; i++) begin
      tick();
      check({tag, ":early_res"}, res0_valid_o | res1_valid_o, 1'b0);
    end
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = data;
    tick();
    mem_res_valid_i = 1'b0;
    mem_res_data_i  = '0;
    check({tag, ":res_v"}, p ? res1_valid_o : res0_valid_o, 1'b1);
    check({tag, ":res_d"}, p ? res1_data_o : res0_data_o, data);
    check({tag, ":oth_v"}, p ? res0_valid_o : res1_valid_o, 1'b0);
    check({tag, ":oth_d"}, p ? res0_data_o : res1_data_o, 128'h0);
    check({tag, ":mres_rdy_off"}, mem_res_ready_o, 1'b0);
    for (int i = 0; i < resp_stall; i++) begin
      tick();
      check({tag, ":hold_v"}, p ? res1_valid_o : res0_valid_o, 1'b1);
      check({tag, ":hold_d"}, p ? res1_data_o : res0_data_o, data);
      check({tag, ":nogrant_r"}, req0_ready_o | req1_ready_o, 1'b0);
    end
    if (p) res1_ready_i = 1'b1;
    else   res0_ready_i = 1'b1;
    tick();
    res0_ready_i = 1'b0;
    res1_ready_i = 1'b0;
    check({tag, ":idle"}, busy_o, 1'b0);
    check({tag, ":res_done"}, res0_valid_o | res1_valid_o, 1'b0);
  endtask

  initial begin
    logic [31:0] a0, a1;
    int          c0, c1;

    rst_i = 1'b1;
    req0_valid_i = 1'b0; req0_addr_i = '0; res0_ready_i = 1'b0;
    req1_valid_i = 1'b0; req1_addr_i = '0; res1_ready_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    #2;
    check("rst:busy", busy_o, 1'b0);
    check("rst:mreq_v", mem_req_valid_o, 1'b0);
    check("rst:mreq_a", mem_req_addr_o, 32'h0);
    check("rst:mres_rdy", mem_res_ready_o, 1'b0);
    check("rst:res_v", {res0_valid_o, res1_valid_o}, 2'b00);
    check("rst:grant", grant_o, 1'b0);
    check("rst:timeout", timeout_o, 1'b0);
    #11;
    rst_i = 1'b0;
    tick();

    // Single icache refill.
    req0_valid_i = 1'b1;
    req0_addr_i  = 32'h0000_1000;
    serve("single", 1'b0, 32'h0000_1000, 128'hDEADBEEF_00000000_00000000_00000001, 0, 3, 0);
    req0_valid_i = 1'b0;

    // Both ports continuously requesting from reset: strict alternation.
    do_reset();
    tick();
    c0 = 0; c1 = 0;
    req0_valid_i = 1'b1; req0_addr_i = 32'h0000_2000;
    req1_valid_i = 1'b1; req1_addr_i = 32'h0000_8000;
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        a0 = req0_addr_i;
        serve("rr0", 1'b0, a0, blk_of(a0), 0, 1, 0);
        c0++;
        if (c0 == 4) req0_valid_i = 1'b0;
        else         req0_addr_i  = a0 + 32'h40;
      end else begin
        a1 = req1_addr_i;
        serve("rr1", 1'b1, a1, blk_of(a1), 0, 2, 0);
        c1++;
        if (c1 == 4) req1_valid_i = 1'b0;
        else         req1_addr_i  = a1 + 32'h40;
      end
    end

    // Back-pressure on both lowX request and icache response; dcache waits.
    req0_valid_i = 1'b1; req0_addr_i = 32'h0000_5000;
    req1_valid_i = 1'b1; req1_addr_i = 32'h0000_6000;
    serve("stall", 1'b0, 32'h0000_5000, blk_of(32'h0000_5000), 5, 1, 3);
    req0_valid_i = 1'b0;
    serve("after_stall", 1'b1, 32'h0000_6000, blk_of(32'h0000_6000), 0, 0, 0);
    req1_valid_i = 1'b0;

    // Watchdog with TIMEOUT_CYC=16.
    req0_valid_i = 1'b1; req0_addr_i = 32'h0000_7000;
    #1;
    tick();
    req0_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("wdog:k%0d", k), timeout_o, k >= 16);
    end
    check("wdog:still_wait", mem_res_ready_o, 1'b1);
    mem_res_valid_i = 1'b1; mem_res_data_i = blk_of(32'h0000_7000);
    tick();
    mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    check("wdog:res_v", res0_valid_o, 1'b1);
    check("wdog:res_d", res0_data_o, blk_of(32'h0000_7000));
    res0_ready_i = 1'b1;
    tick();
    res0_ready_i = 1'b0;
    check("wdog:sticky", timeout_o, 1'b1);
    check("wdog:idle", busy_o, 1'b0);

    // Reset in the middle of a dcache S_WAIT.
    req1_valid_i = 1'b1; req1_addr_i = 32'h0000_3000;
    #1;
    tick();
    req1_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    tick();
    check("mrst:in_wait", mem_res_ready_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("mrst:busy", busy_o, 1'b0);
    check("mrst:mres_rdy", mem_res_ready_o, 1'b0);
    check("mrst:mreq_a", mem_req_addr_o, 32'h0);
    check("mrst:grant", grant_o, 1'b0);
    check("mrst:timeout", timeout_o, 1'b0);
    check("mrst:res1_v", res1_valid_o, 1'b0);
    #2;
    rst_i = 1'b0;
    tick();
    req0_valid_i = 1'b1; req0_addr_i = 32'h0000_4000;
    serve("post_rst", 1'b0, 32'h0000_4000, blk_of(32'h0000_4000), 0, 2, 0);
    req0_valid_i = 1'b0;

    // Spurious lowX response while idle.
    mem_res_valid_i = 1'b1; mem_res_data_i = 128'hBAD;
    #1;
    check("spur:mres_rdy", mem_res_ready_o, 1'b0);
    tick();
    check("spur:busy", busy_o, 1'b0);
    check("spur:res_v", {res0_valid_o, res1_valid_o}, 2'b00);
    tick();
    mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    check("spur:busy2", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
